mem_arbiter: RTL and testbench

Arbiter and sequencer for the single-ported unified RAM in the minimal SoC. It shares the RAM between the instruction-fetch port and the MEM-stage load/store port. It serialises accesses through a fixed-latency RAM and returns one-cycle acknowledges. It also drives a stall request to the pipeline controller.

---
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the pipeline requesters (IF, MEM), the unified RAM and the arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/RAM side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;

    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    logic              ram_ce;
    logic              ram_we;
    logic [3:0]        ram_sel;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic              stall_req;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata, ram_rdata,
        output if_rdata, if_ack, mem_rdata, mem_ack,
               ram_ce, ram_we, ram_sel, ram_addr, ram_wdata, stall_req
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata, ram_rdata,
        input  if_rdata, if_ack, mem_rdata, mem_ack,
               ram_ce, ram_we, ram_sel, ram_addr, ram_wdata, stall_req
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the single-ported unified RAM between instruction fetch and load/store, one
// access at a time through a fixed-latency RAM, with one-cycle acks and a pipeline stall.
module mem_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int RAM_LAT       = 2,
    parameter int IF_STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic       OWNER_IF   = 1'b0;
    localparam logic       OWNER_MEM  = 1'b1;
    localparam logic [3:0] WAIT_LOAD  = 4'(RAM_LAT - 1);
    localparam logic [3:0] STARVE_MAX = 4'(IF_STARVE_MAX);

    logic [1:0]        state_q,     state_d;
    logic              owner_q,     owner_d;
    logic [3:0]        starve_q,    starve_d;
    logic [3:0]        wait_q,      wait_d;
    logic              ram_ce_q,    ram_ce_d;
    logic              ram_we_q,    ram_we_d;
    logic [3:0]        ram_sel_q,   ram_sel_d;
    logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              if_ack_q,    if_ack_d;
    logic              mem_ack_q,   mem_ack_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              grant_if;

    // IF wins when MEM is idle, or when it has already lost IF_STARVE_MAX times in a row.
    assign grant_if = bus.if_req & (~bus.mem_req | (starve_q == STARVE_MAX));

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        wait_d      = wait_q;
        ram_ce_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_sel_d   = ram_sel_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (!bus.if_req) starve_d = '0;
                if (bus.if_req || bus.mem_req) begin
                    state_d  = ST_ISSUE;
                    ram_ce_d = 1'b1;
                    if (grant_if) begin
                        owner_d    = OWNER_IF;
                        starve_d   = '0;
                        ram_sel_d  = 4'hF;
                        ram_addr_d = bus.if_addr;
                    end else begin
                        owner_d     = OWNER_MEM;
                        ram_we_d    = bus.mem_we;
                        ram_sel_d   = bus.mem_sel;
                        ram_addr_d  = bus.mem_addr;
                        ram_wdata_d = bus.mem_wdata;
                        if (bus.if_req && starve_q != STARVE_MAX) starve_d = starve_q + 4'd1;
                    end
                end
            end
            ST_ISSUE: begin
                wait_d  = WAIT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_q == '0) begin
                    state_d = ST_RESP;
                    if (owner_q == OWNER_MEM) begin
                        mem_rdata_d = bus.ram_rdata;
                        mem_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = bus.ram_rdata;
                        if_ack_d   = 1'b1;
                    end
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values.
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWNER_IF;
            starve_q    <= '0;
            wait_q      <= '0;
            ram_ce_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_sel_q   <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            wait_q      <= wait_d;
            ram_ce_q    <= ram_ce_d;
            ram_we_q    <= ram_we_d;
            ram_sel_q   <= ram_sel_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign bus.ram_ce    = ram_ce_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_sel   = ram_sel_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.mem_ack   = mem_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.stall_req = (bus.if_req & ~if_ack_q) | (bus.mem_req & ~mem_ack_q);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected RAM strobes and acks into
// queues; negedge monitors pop and compare whenever the DUT presents ram_ce or an ack.
module tb_mem_arbiter;
    localparam int RAM_LAT = 2;
    localparam int ACK_LAT = 2 + RAM_LAT;
    localparam int PERIOD  = RAM_LAT + 3;

    typedef struct {
        bit          we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;
    } ram_exp_t;

    typedef struct {
        bit          is_mem;
        bit          chk_data;
        logic [31:0] data;
        int          cyc;
    } resp_exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    ram_exp_t  ram_q[$];
    resp_exp_t resp_q[$];

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .RAM_LAT(RAM_LAT), .IF_STARVE_MAX(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    // RAM model: words default to {addr[15:0], ~addr[15:0]}, byte-enabled writes.
    logic [31:0] ram_mem [logic [31:0]];
    logic [31:0] pipe [RAM_LAT];
    logic        pv   [RAM_LAT];

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : {a[15:0], ~a[15:0]};
    endfunction

    always @(posedge clk) begin
        logic [31:0] cur;
        for (int i = RAM_LAT - 1; i > 0; i--) begin
            pipe[i] <= pipe[i-1];
            pv[i]   <= pv[i-1];
        end
        cur = ram_rd(bus.ram_addr);
        pv[0]   <= bus.ram_ce;
        pipe[0] <= cur;
        if (bus.ram_ce && bus.ram_we) begin
            for (int b = 0; b < 4; b++)
                if (bus.ram_sel[b]) cur[8*b +: 8] = bus.ram_wdata[8*b +: 8];
            ram_mem[bus.ram_addr] = cur;
        end
    end

    assign bus.ram_rdata = pv[RAM_LAT-1] ? pipe[RAM_LAT-1] : 32'hBAD0_BAD0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic void exp_ram(input bit we, input logic [3:0] sel, input logic [31:0] addr,
                                    input logic [31:0] wdata, input int c);
        ram_exp_t e;
        e.we = we; e.sel = sel; e.addr = addr; e.wdata = wdata; e.cyc = c;
        ram_q.push_back(e);
    endfunction

    function automatic void exp_resp(input bit is_mem, input bit chk, input logic [31:0] data,
                                     input int c);
        resp_exp_t e;
        e.is_mem = is_mem; e.chk_data = chk; e.data = data; e.cyc = c;
        resp_q.push_back(e);
    endfunction

    // RAM-side monitor.
    always @(negedge clk) begin
        ram_exp_t e;
        if (rst_n) begin
            if (bus.ram_ce) begin
                if (ram_q.size() == 0) note_fail("unexpected_ram_ce");
                else begin
                    e = ram_q.pop_front();
                    check("ram_ce_cycle", cyc, e.cyc);
                    check("ram_we", {31'd0, bus.ram_we}, {31'd0, e.we});
                    check("ram_sel", {28'd0, bus.ram_sel}, {28'd0, e.sel});
                    check("ram_addr", bus.ram_addr, e.addr);
                    if (e.we) check("ram_wdata", bus.ram_wdata, e.wdata);
                end
            end else begin
                check("ram_we_idle", {31'd0, bus.ram_we}, 32'd0);
            end
        end
    end

    // Response-side monitor.
    always @(negedge clk) begin
        resp_exp_t e;
        if (rst_n) begin
            check("ack_exclusive", {31'd0, bus.if_ack & bus.mem_ack}, 32'd0);
            if (bus.if_ack || bus.mem_ack) begin
                if (resp_q.size() == 0) note_fail("unexpected_ack");
                else begin
                    e = resp_q.pop_front();
                    check("ack_port_is_mem", {31'd0, bus.mem_ack}, {31'd0, e.is_mem});
                    check("ack_cycle", cyc, e.cyc);
                    if (e.chk_data)
                        check("rdata", e.is_mem ? bus.mem_rdata : bus.if_rdata, e.data);
                end
            end
        end
    end

    // Holds requests until their acks, dropping each in the cycle after its ack.
    task automatic hold_until_done(input bit want_if, input bit want_mem, input int stall_end);
        bit if_done  = !want_if;
        bit mem_done = !want_mem;
        int budget   = 0;
        while (!(if_done && mem_done)) begin
            @(negedge clk);
            if (stall_end > 0)
                check("stall_req", {31'd0, bus.stall_req}, {31'd0, cyc < stall_end});
            if (bus.if_ack)  if_done  = 1'b1;
            if (bus.mem_ack) mem_done = 1'b1;
            @(posedge clk); #1;
            if (if_done)  bus.if_req  = 1'b0;
            if (mem_done) bus.mem_req = 1'b0;
            budget++;
            if (budget > 60) begin
                note_fail("ack_timeout");
                bus.if_req  = 1'b0;
                bus.mem_req = 1'b0;
                break;
            end
        end
    endtask

    task automatic single(input bit is_mem, input bit we, input logic [3:0] sel,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_data);
        int c0;
        @(posedge clk); #1;
        c0 = cyc;
        if (is_mem) begin
            bus.mem_req = 1'b1; bus.mem_we = we; bus.mem_sel = sel;
            bus.mem_addr = addr; bus.mem_wdata = wdata;
            exp_ram(we, sel, addr, wdata, c0 + 1);
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
            exp_ram(1'b0, 4'hF, addr, 32'd0, c0 + 1);
        end
        exp_resp(is_mem, !we, exp_data, c0 + ACK_LAT);
        hold_until_done(!is_mem, is_mem, 0);
    endtask

    initial begin
        int c0;
        int mem_acks;
        int budget;
        bit if_seen;

        ram_mem[32'h100] = 32'hDEAD_BEEF;
        rst_n = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_sel = 4'h0;
        bus.mem_addr = '0; bus.mem_wdata = '0;

        // Reset held with a pending fetch: nothing may move.
        repeat (3) begin
            @(negedge clk);
            check("rst_ram_ce", {31'd0, bus.ram_ce}, 32'd0);
        end
        check("rst_acks", {30'd0, bus.if_ack, bus.mem_ack}, 32'd0);
        check("rst_ram_we_sel", {27'd0, bus.ram_we, bus.ram_sel}, 32'd0);
        check("rst_ram_addr", bus.ram_addr, 32'd0);
        check("rst_ram_wdata", bus.ram_wdata, 32'd0);
        check("rst_if_rdata", bus.if_rdata, 32'd0);
        check("rst_mem_rdata", bus.mem_rdata, 32'd0);
        #1 rst_n = 1'b1;
        c0 = cyc;
        exp_ram(1'b0, 4'hF, 32'h100, 32'd0, c0 + 1);
        exp_resp(1'b0, 1'b1, 32'hDEAD_BEEF, c0 + ACK_LAT);
        hold_until_done(1'b1, 1'b0, 0);

        // Single fetch, store with partial byte enables, then read-back.
        single(1'b0, 1'b0, 4'hF, 32'h108, 32'd0, 32'h0108_FEF7);
        single(1'b1, 1'b1, 4'b0011, 32'h204, 32'h1234_5678, 32'd0);
        single(1'b1, 1'b0, 4'hF, 32'h204, 32'd0, 32'h0204_5678);

        // Contention: MEM first, IF at the next IDLE, stall high until IF ack.
        @(posedge clk); #1;
        c0 = cyc;
        bus.if_req = 1'b1; bus.if_addr = 32'h300;
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_sel = 4'hF; bus.mem_addr = 32'h400;
        exp_ram(1'b0, 4'hF, 32'h400, 32'd0, c0 + 1);
        exp_ram(1'b0, 4'hF, 32'h300, 32'd0, c0 + 1 + PERIOD);
        exp_resp(1'b1, 1'b1, 32'h0400_FBFF, c0 + ACK_LAT);
        exp_resp(1'b0, 1'b1, 32'h0300_FCFF, c0 + ACK_LAT + PERIOD);
        hold_until_done(1'b1, 1'b1, c0 + ACK_LAT + PERIOD);

        // Starvation: four MEM grants, then IF forced, then MEM resumes.
        @(posedge clk); #1;
        c0 = cyc;
        bus.if_req = 1'b1; bus.if_addr = 32'h300;
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_sel = 4'hF; bus.mem_addr = 32'h400;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) begin
                exp_ram(1'b0, 4'hF, 32'h300, 32'd0, c0 + 1 + k * PERIOD);
                exp_resp(1'b0, 1'b1, 32'h0300_FCFF, c0 + ACK_LAT + k * PERIOD);
            end else begin
                exp_ram(1'b0, 4'hF, 32'h400, 32'd0, c0 + 1 + k * PERIOD);
                exp_resp(1'b1, 1'b1, 32'h0400_FBFF, c0 + ACK_LAT + k * PERIOD);
            end
        end
        mem_acks = 0;
        if_seen  = 1'b0;
        budget   = 0;
        while (mem_acks < 5 || !if_seen) begin
            @(negedge clk);
            if (bus.mem_ack) mem_acks++;
            if (bus.if_ack)  if_seen = 1'b1;
            @(posedge clk); #1;
            if (if_seen) bus.if_req = 1'b0;
            if (mem_acks >= 5) bus.mem_req = 1'b0;
            budget++;
            if (budget > 80) begin
                note_fail("starve_timeout");
                break;
            end
        end
        bus.if_req = 1'b0; bus.mem_req = 1'b0;

        // Reset during WAIT of a load: that access must never be acked.
        @(posedge clk); #1;
        c0 = cyc;
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_sel = 4'hF; bus.mem_addr = 32'h400;
        exp_ram(1'b0, 4'hF, 32'h400, 32'd0, c0 + 1);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        bus.mem_req = 1'b0;
        @(negedge clk);
        check("midrst_acks", {30'd0, bus.if_ack, bus.mem_ack}, 32'd0);
        check("midrst_ram_ce", {31'd0, bus.ram_ce}, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        single(1'b1, 1'b0, 4'hF, 32'h208, 32'd0, 32'h0208_FDF7);

        repeat (10) @(negedge clk);
        check("resp_q_drained", resp_q.size(), 32'd0);
        check("ram_q_drained", ram_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
